// File: rtl/pu_write_arbiter_if.sv
// PU-to-output-buffer write bus: per-PU write strobes/data/ready
// plus the single merged output-buffer write port.
interface pu_write_arbiter_if #(
   parameter int NUM_PU     = 2,
   parameter int DATA_WIDTH = 64,
   parameter int ID_W       = $clog2(NUM_PU)
);
   logic [NUM_PU-1:0]            pu_write_req;
   logic [NUM_PU*DATA_WIDTH-1:0] pu_write_data;
   logic [NUM_PU-1:0]            pu_write_ready;
   logic                         outbuf_write_ready;
   logic                         outbuf_write_req;
   logic [DATA_WIDTH-1:0]        outbuf_write_data;
   logic [ID_W-1:0]              outbuf_write_id;

   modport master (
      input  pu_write_req,
      input  pu_write_data,
      input  outbuf_write_ready,
      output pu_write_ready,
      output outbuf_write_req,
      output outbuf_write_data,
      output outbuf_write_id
   );

   modport slave (
      output pu_write_req,
      output pu_write_data,
      output outbuf_write_ready,
      input  pu_write_ready,
      input  outbuf_write_req,
      input  outbuf_write_data,
      input  outbuf_write_id
   );
endinterface

// File: rtl/pu_write_arbiter.sv
// Round-robin merge of NUM_PU write streams into one output-buffer port,
// with 2-deep per-PU FIFOs and a per-layer beat counter producing done.
module pu_write_arbiter #(
   parameter int NUM_PU     = 2,
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 16,
   parameter int ID_W       = $clog2(NUM_PU)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] expected_writes,
   pu_write_arbiter_if.master   bus,
   output logic                 done,
   output logic                 overflow
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] fifo_q [NUM_PU][2];
   logic [DATA_WIDTH-1:0] fifo_d [NUM_PU][2];
   logic [1:0]            fcnt_q [NUM_PU];
   logic [1:0]            fcnt_d [NUM_PU];
   logic [ID_W-1:0]       rr_q, rr_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  exp_q, exp_d;
   logic                  ovf_q, ovf_d;
   logic                  oreq_q, oreq_d;
   logic [DATA_WIDTH-1:0] odata_q, odata_d;
   logic [ID_W-1:0]       oid_q, oid_d;

   logic [NUM_PU-1:0]     ready;
   logic [NUM_PU-1:0]     push;
   logic [NUM_PU-1:0]     nonempty;
   logic [NUM_PU-1:0]     gnt_vec;
   logic                  gnt;
   logic [ID_W-1:0]       gidx;
   logic [ID_W:0]         scan;
   logic                  drop;

   always_comb begin
      for (int i = 0; i < NUM_PU; i++) begin
         ready[i]    = (state_q == S_RUN) && (fcnt_q[i] != 2'd2);
         nonempty[i] = (fcnt_q[i] != 2'd0);
      end
      push = bus.pu_write_req & ready;
      drop = |(bus.pu_write_req & ~ready);
   end

   // first non-empty FIFO at or after rr_q, wrapping
   always_comb begin
      gnt  = 1'b0;
      gidx = '0;
      scan = '0;
      if (state_q == S_RUN && bus.outbuf_write_ready) begin
         for (int k = 0; k < NUM_PU; k++) begin
            scan = {1'b0, rr_q} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(NUM_PU))
               scan = scan - (ID_W+1)'(NUM_PU);
            if (!gnt && nonempty[scan[ID_W-1:0]]) begin
               gnt  = 1'b1;
               gidx = scan[ID_W-1:0];
            end
         end
      end
      gnt_vec = gnt ? (NUM_PU'(1) << gidx) : '0;
      if (!gnt)
         rr_d = rr_q;
      else if (gidx == ID_W'(NUM_PU-1))
         rr_d = '0;
      else
         rr_d = gidx + ID_W'(1);
   end

   always_comb begin
      fifo_d = fifo_q;
      fcnt_d = fcnt_q;
      for (int i = 0; i < NUM_PU; i++) begin
         if (gnt_vec[i])
            fifo_d[i][0] = fifo_q[i][1];
         if (push[i]) begin
            if (fcnt_q[i] == 2'd0 || (fcnt_q[i] == 2'd1 && gnt_vec[i]))
               fifo_d[i][0] = bus.pu_write_data[i*DATA_WIDTH +: DATA_WIDTH];
            else
               fifo_d[i][1] = bus.pu_write_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
         fcnt_d[i] = fcnt_q[i] + 2'(push[i]) - 2'(gnt_vec[i]);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               exp_d   = expected_writes;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = (expected_writes == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (gnt) begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
               if (cnt_q == exp_q - CNT_WIDTH'(1))
                  state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (drop)
         ovf_d = 1'b1;
      oreq_d  = gnt;
      odata_d = gnt ? fifo_q[gidx][0] : odata_q;
      oid_d   = gnt ? gidx : oid_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         for (int i = 0; i < NUM_PU; i++) begin
            fifo_q[i][0] <= '0;
            fifo_q[i][1] <= '0;
            fcnt_q[i]    <= '0;
         end
         rr_q    <= '0;
         cnt_q   <= '0;
         exp_q   <= '0;
         ovf_q   <= 1'b0;
         oreq_q  <= 1'b0;
         odata_q <= '0;
         oid_q   <= '0;
      end else begin
         state_q <= state_d;
         fifo_q  <= fifo_d;
         fcnt_q  <= fcnt_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         ovf_q   <= ovf_d;
         oreq_q  <= oreq_d;
         odata_q <= odata_d;
         oid_q   <= oid_d;
      end
   end

   assign bus.pu_write_ready    = ready;
   assign bus.outbuf_write_req  = oreq_q;
   assign bus.outbuf_write_data = odata_q;
   assign bus.outbuf_write_id   = oid_q;
   assign done                  = (state_q == S_DONE);
   assign overflow              = ovf_q;

endmodule

// File: tb/tb_pu_write_arbiter.sv
// Randomized and directed bench for pu_write_arbiter against a
// queue-based reference model of the arbitration rules.
module tb_pu_write_arbiter;

   localparam int NP = 2;
   localparam int DW = 64;
   localparam int CW = 16;
   localparam int IW = $clog2(NP);

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [CW-1:0] expw;
   logic          done;
   logic          overflow;

   pu_write_arbiter_if #(.NUM_PU(NP), .DATA_WIDTH(DW), .ID_W(IW)) bus();

   pu_write_arbiter #(
      .NUM_PU(NP), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .ID_W(IW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .expected_writes (expw),
      .bus             (bus.master),
      .done            (done),
      .overflow        (overflow)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model: FIFOs as queues, layer state as small ints
   logic [DW-1:0] mq [NP][$];
   int            ms;
   int            mrr;
   int            mcnt;
   int            mexp;
   bit            mreq;
   bit            movf;
   logic [DW-1:0] mdata;
   int            mid;

   function automatic void mreset();
      for (int i = 0; i < NP; i++) mq[i].delete();
      ms = 0; mrr = 0; mcnt = 0; mexp = 0;
      mreq = 0; movf = 0; mdata = '0; mid = 0;
   endfunction

   task automatic tick();
      logic [NP-1:0] r;
      int g;
      for (int i = 0; i < NP; i++)
         r[i] = (ms == 1) && (mq[i].size() < 2);
      check("pu_ready", 64'(bus.pu_write_ready), 64'(r));
      g = -1;
      if (ms == 1 && bus.outbuf_write_ready)
         for (int k = 0; k < NP; k++)
            if (g < 0 && mq[(mrr + k) % NP].size() > 0)
               g = (mrr + k) % NP;
      mreq = (g >= 0);
      if (g >= 0) begin
         mdata = mq[g].pop_front();
         mid   = g;
         mrr   = (g + 1) % NP;
      end
      if (start && ms == 0) movf = 0;
      for (int i = 0; i < NP; i++) begin
         if (bus.pu_write_req[i]) begin
            if (r[i]) mq[i].push_back(bus.pu_write_data[i*DW +: DW]);
            else      movf = 1;
         end
      end
      case (ms)
         0: if (start) begin
               mexp = int'(expw);
               mcnt = 0;
               ms   = (expw == 0) ? 2 : 1;
            end
         1: if (g >= 0) begin
               mcnt++;
               if (mcnt == mexp) ms = 2;
            end
         default: ms = 0;
      endcase
      @(negedge clk);
      check("ob_req", 64'(bus.outbuf_write_req), 64'(mreq));
      if (mreq) begin
         check("ob_data", bus.outbuf_write_data, mdata);
         check("ob_id", 64'(bus.outbuf_write_id), 64'(mid));
      end
      check("done", 64'(done), 64'(ms == 2));
      check("overflow", 64'(overflow), 64'(movf));
   endtask

   task automatic drive(input bit st, input int ew, input logic [NP-1:0] rq,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input bit obr);
      start                  = st;
      expw                   = CW'(ew);
      bus.pu_write_req       = rq;
      bus.pu_write_data      = {d1, d0};
      bus.outbuf_write_ready = obr;
      tick();
      start = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ready"}, 64'(bus.pu_write_ready), 64'(0));
      check({tag, "_req"}, 64'(bus.outbuf_write_req), 64'(0));
      check({tag, "_data"}, bus.outbuf_write_data, 64'(0));
      check({tag, "_id"}, 64'(bus.outbuf_write_id), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_ovf"}, 64'(overflow), 64'(0));
   endtask

   initial begin
      reset                  = 1'b0;
      start                  = 1'b0;
      expw                   = '0;
      bus.pu_write_req       = '0;
      bus.pu_write_data      = '0;
      bus.outbuf_write_ready = 1'b0;
      mreset();
      #2;
      check_zero("rst");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // single-PU stream
      drive(1, 8, 2'b00, 0, 0, 1);
      for (int v = 1; v <= 8; v++) drive(0, 0, 2'b01, DW'(v), 0, 1);
      repeat (3) drive(0, 0, 2'b00, 0, 0, 1);

      // round-robin fairness, writes spaced so both FIFOs keep room
      drive(1, 6, 2'b00, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 2'b11, DW'(16'hA0 + k), DW'(16'hB0 + k), 1);
         drive(0, 0, 2'b00, 0, 0, 1);
      end
      repeat (4) drive(0, 0, 2'b00, 0, 0, 1);

      // backpressure on PU1
      drive(1, 2, 2'b00, 0, 0, 0);
      for (int k = 0; k < 5; k++) drive(0, 0, 2'b10, 0, DW'(16'hC0 + k), 0);
      repeat (4) drive(0, 0, 2'b00, 0, 0, 1);

      // write while not ready in IDLE, then zero-length layer clears it
      drive(0, 0, 2'b01, 64'hDEAD, 0, 1);
      repeat (2) drive(0, 0, 2'b00, 0, 0, 1);
      drive(1, 0, 2'b00, 0, 0, 1);
      repeat (2) drive(0, 0, 2'b00, 0, 0, 1);

      // leftover beat carries into the next layer
      drive(1, 2, 2'b00, 0, 0, 1);
      for (int k = 0; k < 3; k++) drive(0, 0, 2'b01, DW'(16'hE0 + k), 0, 1);
      repeat (2) drive(0, 0, 2'b00, 0, 0, 1);
      drive(1, 1, 2'b00, 0, 0, 1);
      repeat (3) drive(0, 0, 2'b00, 0, 0, 1);

      // randomized layers
      for (int l = 0; l < 30; l++) begin
         drive(1, int'($urandom_range(1, 8)), 2'b00, 0, 0, 1);
         for (int c = 0; c < 20; c++)
            drive(0, 0, NP'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
         repeat (2) drive(0, 0, 2'b00, 0, 0, 1);
      end
      repeat (4) drive(0, 0, 2'b00, 0, 0, 1);

      // async reset with beats queued
      drive(1, 4, 2'b00, 0, 0, 0);
      drive(0, 0, 2'b11, 64'h5A, 64'hA5, 0);
      drive(0, 0, 2'b00, 0, 0, 1);
      #2;
      reset = 1'b0;
      #1;
      check_zero("arst");
      mreset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) drive(0, 0, 2'b00, 0, 0, 1);
      drive(1, 3, 2'b00, 0, 0, 1);
      repeat (4) drive(0, 0, 2'b00, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
